// File: rtl/demux18_router.sv
// 1-to-8 registered demultiplexer with per-channel one-beat holding registers.
// Optional statistics counters are enabled by defining DEMUX18_STATS_EN.
module demux18_router #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable_b,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [2:0]            i_in_select,
    input  logic [DATA_W-1:0]     i_in_data,
    output logic [7:0]            o_out_valid,
    input  logic [7:0]            i_out_ready,
    output logic [8*DATA_W-1:0]   o_out_data,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_drop_cnt,
    output logic [CNT_W-1:0]      o_deliver_cnt
);

    typedef enum logic {StEmpty, StFull} state_e;

    logic w_accept;
    logic w_route;

    // A full channel can still take a beat in the cycle its consumer drains it.
    assign o_in_ready = i_enable_b | ~o_out_valid[i_in_select] | i_out_ready[i_in_select];
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_route    = w_accept & ~i_enable_b;
    assign o_busy     = |o_out_valid;

    for (genvar n = 0; n < 8; n++) begin : g_ch
        state_e            r_state;
        logic [DATA_W-1:0] r_data;
        logic              w_load;

        assign w_load = w_route && (i_in_select == 3'(n));

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                r_state <= StEmpty;
                r_data  <= '0;
            end else begin
                unique case (r_state)
                    StEmpty: begin
                        if (w_load) begin
                            r_state <= StFull;
                            r_data  <= i_in_data;
                        end
                    end
                    StFull: begin
                        if (w_load) begin
                            r_data <= i_in_data;
                        end else if (i_out_ready[n]) begin
                            r_state <= StEmpty;
                        end
                    end
                    default: r_state <= StEmpty;
                endcase
            end
        end

        assign o_out_valid[n]                   = (r_state == StFull);
        assign o_out_data[n*DATA_W +: DATA_W]   = r_data;
    end

`ifdef DEMUX18_STATS_EN
    localparam logic [CNT_W+3:0] CntMax = {4'b0000, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_deliver_cnt;
    logic [7:0]       w_drain;
    logic [3:0]       w_deliver_num;
    logic [CNT_W+3:0] w_drop_sum;
    logic [CNT_W+3:0] w_deliver_sum;

    assign w_drain = o_out_valid & i_out_ready;

    always_comb begin
        w_deliver_num = '0;
        for (int n = 0; n < 8; n++) begin
            w_deliver_num = w_deliver_num + {3'b000, w_drain[n]};
        end
    end

    // Sums are widened so a saturated counter plus up to 8 never wraps.
    assign w_drop_sum    = {4'b0000, r_drop_cnt} +
                           {{(CNT_W+3){1'b0}}, (w_accept & i_enable_b)};
    assign w_deliver_sum = {4'b0000, r_deliver_cnt} + {{CNT_W{1'b0}}, w_deliver_num};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_drop_cnt    <= '0;
            r_deliver_cnt <= '0;
        end else begin
            r_drop_cnt    <= (w_drop_sum > CntMax) ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
            r_deliver_cnt <= (w_deliver_sum > CntMax) ? {CNT_W{1'b1}} :
                             w_deliver_sum[CNT_W-1:0];
        end
    end

    assign o_drop_cnt    = r_drop_cnt;
    assign o_deliver_cnt = r_deliver_cnt;
`else
    assign o_drop_cnt    = '0;
    assign o_deliver_cnt = '0;
`endif

endmodule
